// File: rtl/uart_tx_fifo_reader.sv
// Drains a first-word-fall-through byte FIFO onto a UART line as 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// tx falls on the edge that samples empty=0. The FIFO is only looked at while idle.
module uart_tx_fifo_reader #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] pop_data,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt, pop_nxt, done_nxt;
  logic          wrap;
`ifdef UART_TX_PARITY_EN
  logic          par, par_nxt;
`endif

  assign wrap    = (baud_cnt == BAUD_LAST);
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      pop      <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      pop      <= pop_nxt;
      tx_done  <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = wrap ? '0 : baud_cnt + CW'(1);
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = tx;
    pop_nxt   = 1'b0;
    done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        // Baud counter parks at zero so the start bit is a full BIT_CYC long.
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        if (!empty) begin
          state_nxt = START;
          shift_nxt = pop_data;
          bit_nxt   = '0;
          pop_nxt   = 1'b1;
          tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^pop_data;
`endif
        end
      end
      START: begin
        if (wrap) begin
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = par;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
            bit_nxt   = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (wrap) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (wrap) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader at BIT_CYC=10 (CLK_HZ=1000, BAUD=100).
module tb_uart_tx_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty;
  logic [7:0] pop_data;
  logic       pop, tx, tx_busy, tx_done;

  int vecs = 0;
  int errs = 0;
  int pop_cnt = 0;

  uart_tx_fifo_reader #(.CLK_HZ(1000), .BAUD(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .empty    (empty),
    .pop_data (pop_data),
    .pop      (pop),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walks one frame from its start edge (k=0) to the first idle cycle (k=100),
  // sampling on each falling edge. Inputs are replaced right after the k=0 sample.
  task automatic check_frame(input logic [7:0] b, input logic nxt_empty, input logic [7:0] nxt_data);
    logic e_tx;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (pop === 1'b1) pop_cnt++;
      if (k < 10)       e_tx = 1'b0;
      else if (k < 90)  e_tx = b[(k / 10) - 1];
      else              e_tx = 1'b1;
      if (k == 100)
        chk($sformatf("frame_%h_end", b), {tx, pop, tx_busy, tx_done}, 4'b1001);
      else
        chk($sformatf("frame_%h_k%0d", b, k), {tx, pop, tx_busy, tx_done},
            {e_tx, (k == 0), 1'b1, 1'b0});
      if (k == 0) begin
        empty    = nxt_empty;
        pop_data = nxt_data;
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    empty    = 1'b0;
    pop_data = 8'hA5;

    // Reset held with data available: line stays idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_hold", {tx, pop, tx_busy, tx_done}, 4'b1000);
    end

    // Release: the very next edge starts the 0xA5 frame.
    rst = 1'b1;
    check_frame(8'hA5, 1'b1, 8'h00);

    // Back-to-back 0x00 then 0xFF, FIFO non-empty throughout the first frame.
    pop_cnt  = 0;
    empty    = 1'b0;
    pop_data = 8'h00;
    check_frame(8'h00, 1'b0, 8'hFF);
    check_frame(8'hFF, 1'b1, 8'h00);
    chk("b2b_pop_count", pop_cnt, 2);

    // Empty FIFO: nothing happens.
    pop_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pop === 1'b1) pop_cnt++;
      if (tx !== 1'b1) chk("empty_idle_tx", tx, 1);
    end
    vecs++;
    chk("empty_no_pop", pop_cnt, 0);
    chk("empty_idle_state", {tx, pop, tx_busy, tx_done}, 4'b1000);

    // Reset mid-frame at clock 45 (data bit 3 of 0x55 = 0).
    empty    = 1'b0;
    pop_data = 8'h55;
    @(negedge clk);
    chk("mid_start", {tx, pop, tx_busy}, 3'b011);
    empty = 1'b1;
    repeat (45) @(negedge clk);
    chk("mid_k45_tx", tx, 0);
    #2 rst = 1'b0;
    #1 chk("mid_async_reset", {tx, pop, tx_busy, tx_done}, 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    pop_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pop === 1'b1) pop_cnt++;
      chk("post_reset_idle", {tx, pop, tx_busy, tx_done}, 4'b1000);
    end
    chk("post_reset_no_pop", pop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
